ulpi_reg_arbiter: RTL and testbench

Shares the single ULPI PHY register port (address, write data, write/read request with level acknowledge) among N_CLIENTS independent requesters, e.g. the PHY init sequencer, the host-side register bridge and the debug register dumper. Grants are round-robin, one transaction in flight at a time. Each grant is latched and replayed on the PHY-side handshake. A watchdog aborts transactions the PHY never acknowledges.

---
 rtl/ulpi_reg_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ulpi_reg_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter sharing the ULPI PHY register port among N_CLIENTS requesters.
// One transaction in flight; a watchdog aborts requests the PHY never acknowledges.
module ulpi_reg_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_CLIENTS-1:0]   C_REQ,
  input  logic [N_CLIENTS-1:0]   C_WR,
  input  logic [6*N_CLIENTS-1:0] C_ADDR,
  input  logic [8*N_CLIENTS-1:0] C_WDATA,
  output logic [N_CLIENTS-1:0]   C_ACK,
  output logic [7:0]             C_RDATA,
  output logic                   C_ERR,
  output logic                   BUSY,
  output logic [2:0]             GRANT_ID,
  output logic [5:0]             REG_ADDR,
  output logic [7:0]             REG_DATA_WRITE,
  output logic                   REG_WRITE_REQ,
  input  logic                   REG_WRITE_ACK,
  output logic                   REG_READ_REQ,
  input  logic                   REG_READ_ACK,
  input  logic [7:0]             REG_DATA_READ
);

  // Handshake: a client holds C_REQ (level) until it sees its one-cycle C_ACK;
  // on the PHY side REG_*_REQ stays high until the matching level ack or the
  // watchdog, and a new request is never issued while either ack is still high.

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_q, last_d;
  logic        wr_q, wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        wreq_q, wreq_d;
  logic        rreq_q, rreq_d;
  logic        err_q, err_d;
  logic [15:0] wd_q, wd_d;

  logic [7:0]  req8;
  logic        pick_vld;
  logic [2:0]  pick_id;
  logic        sel_wr;
  logic [5:0]  sel_addr;
  logic [7:0]  sel_wdata;
  logic        ack_match;
  int          idx;

  assign req8 = 8'(C_REQ);

  // Search upward from the client after the last grant, wrapping at N_CLIENTS.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int off = 1; off <= N_CLIENTS; off++) begin
      idx = int'(last_q) + off;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      if (!pick_vld && req8[3'(idx)]) begin
        pick_vld = 1'b1;
        pick_id  = 3'(idx);
      end
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (pick_id == 3'(i)) begin
        sel_wr    = C_WR[i];
        sel_addr  = C_ADDR[6*i +: 6];
        sel_wdata = C_WDATA[8*i +: 8];
      end
    end
  end

  assign ack_match = wr_q ? REG_WRITE_ACK : REG_READ_ACK;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wreq_d  = wreq_q;
    rreq_d  = rreq_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_id;
          last_d  = pick_id;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          if (sel_wr) wdata_d = sel_wdata;
          wreq_d  = sel_wr;
          rreq_d  = !sel_wr;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d = wd_q + 16'd1;
        // An ack on the expiry edge still counts as success.
        if (ack_match) begin
          wreq_d  = 1'b0;
          rreq_d  = 1'b0;
          err_d   = 1'b0;
          if (!wr_q) rdata_d = REG_DATA_READ;
          state_d = RELEASE;
        end else if (wd_d == TIMEOUT_W) begin
          wreq_d  = 1'b0;
          rreq_d  = 1'b0;
          err_d   = 1'b1;
          rdata_d = 8'h00;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!REG_WRITE_ACK && !REG_READ_ACK) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(N_CLIENTS - 1);
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wreq_q  <= wreq_d;
      rreq_q  <= rreq_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    C_ACK = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      C_ACK[i] = (state_q == DONE) && (grant_q == 3'(i));
    end
  end

  assign C_ERR          = (state_q == DONE) && err_q;
  assign C_RDATA        = rdata_q;
  assign BUSY           = (state_q != IDLE);
  assign GRANT_ID       = grant_q;
  assign REG_ADDR       = addr_q;
  assign REG_DATA_WRITE = wdata_q;
  assign REG_WRITE_REQ  = wreq_q;
  assign REG_READ_REQ   = rreq_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: directed client transactions against a small PHY responder,
// with issue and completion records checked from queues by a negedge monitor.
module tb_ulpi_reg_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] c_req;
  logic [N-1:0] c_wr;
  logic [6*N-1:0] c_addr;
  logic [8*N-1:0] c_wdata;
  logic [N-1:0] c_ack;
  logic [7:0]   c_rdata;
  logic         c_err;
  logic         busy;
  logic [2:0]   grant_id;
  logic [5:0]   reg_addr;
  logic [7:0]   reg_data_write;
  logic         reg_write_req;
  logic         reg_write_ack;
  logic         reg_read_req;
  logic         reg_read_ack;
  logic [7:0]   reg_data_read;

  ulpi_reg_arbiter #(.N_CLIENTS(N), .TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst),
    .C_REQ(c_req), .C_WR(c_wr), .C_ADDR(c_addr), .C_WDATA(c_wdata),
    .C_ACK(c_ack), .C_RDATA(c_rdata), .C_ERR(c_err), .BUSY(busy), .GRANT_ID(grant_id),
    .REG_ADDR(reg_addr), .REG_DATA_WRITE(reg_data_write),
    .REG_WRITE_REQ(reg_write_req), .REG_WRITE_ACK(reg_write_ack),
    .REG_READ_REQ(reg_read_req), .REG_READ_ACK(reg_read_ack),
    .REG_DATA_READ(reg_data_read)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_watchdog: got timeout, expected completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  // expected PHY issues {wreq, rreq, addr, wdata} and completions {c_ack, c_err, c_rdata}
  logic [15:0] iss_q[$];
  logic [12:0] exp_q[$];
  logic [7:0]  model_rdata;
  logic [7:0]  model_wdata;

  int          phy_delay;
  int          phy_hold;
  logic        phy_noack;
  logic [7:0]  phy_rdata;
  logic        hold_reqs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_client(input int i, input logic wr, input logic [5:0] a, input logic [7:0] d);
    c_wr[i]          = wr;
    c_addr[6*i +: 6] = a;
    c_wdata[8*i +: 8] = d;
  endtask

  task automatic expect_issue(input logic wr, input logic [5:0] a, input logic [7:0] d);
    if (wr) model_wdata = d;
    iss_q.push_back({wr, ~wr, a, model_wdata});
  endtask

  task automatic expect_done(input int cl, input logic err, input logic is_rd, input logic [7:0] rd);
    logic [3:0] oh;
    oh = 4'b0001 << cl;
    if (err) model_rdata = 8'h00;
    else if (is_rd) model_rdata = rd;
    exp_q.push_back({oh, err, model_rdata});
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0 || busy || c_req != '0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 32'(n < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_reqs"},   32'({reg_write_req, reg_read_req}), 32'd0);
    check({tag, "_c_ack"},  32'(c_ack), 32'd0);
    check({tag, "_c_err"},  32'(c_err), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_addr"},   32'(reg_addr), 32'd0);
    check({tag, "_wdata"},  32'(reg_data_write), 32'd0);
    check({tag, "_rdata"},  32'(c_rdata), 32'd0);
    check({tag, "_grant"},  32'(grant_id), 32'd0);
  endtask

  // PHY responder: acks phy_delay cycles after seeing a request, holds ack phy_hold cycles
  initial begin
    logic is_wr;
    reg_write_ack = 1'b0;
    reg_read_ack  = 1'b0;
    reg_data_read = 8'h00;
    forever begin
      @(negedge clk);
      if ((reg_write_req || reg_read_req) && !phy_noack && !rst) begin
        is_wr = reg_write_req;
        repeat (phy_delay) @(negedge clk);
        if (is_wr) reg_write_ack = 1'b1;
        else begin
          reg_read_ack  = 1'b1;
          reg_data_read = phy_rdata;
        end
        repeat (phy_hold) @(negedge clk);
        reg_write_ack = 1'b0;
        reg_read_ack  = 1'b0;
      end
    end
  end

  // scoreboard monitor; also plays the clients dropping C_REQ on their ack
  initial begin
    logic        prev_req;
    logic        cur;
    logic [15:0] cur_iss;
    logic [12:0] e;
    prev_req = 1'b0;
    cur_iss  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        continue;
      end
      cur = reg_write_req | reg_read_req;
      if (cur) begin
        if (!prev_req) begin
          if (iss_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_issue: got addr 0x%0h, expected no request", reg_addr);
          end else begin
            cur_iss = iss_q.pop_front();
            check("issue", 32'({reg_write_req, reg_read_req, reg_addr, reg_data_write}), 32'(cur_iss));
          end
        end else begin
          check("issue_stable", 32'({reg_write_req, reg_read_req, reg_addr, reg_data_write}), 32'(cur_iss));
        end
      end
      prev_req = cur;
      if (c_ack != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_c_ack: got 0x%0h, expected 0x0", c_ack);
        end else begin
          e = exp_q.pop_front();
          check("completion", 32'({c_ack, c_err, c_rdata}), 32'(e));
        end
        if (exp_q.size() == 0) c_req = '0;
        else if (!hold_reqs) c_req = c_req & ~c_ack;
      end
    end
  end

  // directed stimulus
  initial begin
    int cnt;
    int ack_cyc;
    int viol;
    int cl;
    rst = 1'b1;
    c_req = '0; c_wr = '0; c_addr = '0; c_wdata = '0;
    phy_delay = 0; phy_hold = 1; phy_noack = 1'b0; phy_rdata = 8'h00;
    hold_reqs = 1'b0; model_rdata = 8'h00; model_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // single write, PHY acks 2 cycles after request
    phy_delay = 2;
    set_client(0, 1'b1, 6'h04, 8'h48);
    expect_issue(1'b1, 6'h04, 8'h48);
    expect_done(0, 1'b0, 1'b0, 8'h00);
    c_req[0] = 1'b1;
    @(posedge clk);
    #1;
    check("wr_req_latency", 32'(reg_write_req), 32'd1);
    check("wr_addr", 32'(reg_addr), 32'h04);
    check("wr_data", 32'(reg_data_write), 32'h48);
    check("wr_busy", 32'(busy), 32'd1);
    wait_done("single_write");

    // read from client 2
    phy_delay = 1;
    phy_rdata = 8'h5A;
    set_client(2, 1'b0, 6'h0A, 8'hEE);
    expect_issue(1'b0, 6'h0A, 8'h00);
    expect_done(2, 1'b0, 1'b1, 8'h5A);
    c_req[2] = 1'b1;
    wait_done("read");

    // round-robin with all clients holding requests from reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_rdata = 8'h00;
    model_wdata = 8'h00;
    phy_delay = 0;
    hold_reqs = 1'b1;
    for (int i = 0; i < N; i++) set_client(i, 1'b1, 6'(16 + i), 8'(32 + i));
    for (int k = 0; k < 5; k++) begin
      cl = k % N;
      expect_issue(1'b1, 6'(16 + cl), 8'(32 + cl));
      expect_done(cl, 1'b0, 1'b0, 8'h00);
    end
    c_req = 4'hF;
    wait_done("round_robin");
    hold_reqs = 1'b0;

    // watchdog: PHY never acks a read from client 1
    phy_noack = 1'b1;
    set_client(1, 1'b0, 6'h2A, 8'h00);
    expect_issue(1'b0, 6'h2A, 8'h00);
    expect_done(1, 1'b1, 1'b1, 8'h00);
    c_req[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (reg_read_req) cnt++;
      if (!busy) break;
    end
    check("timeout_req_cycles", 32'(cnt), 32'd8);
    phy_noack = 1'b0;
    wait_done("timeout");

    // sticky write ack held 5 cycles
    phy_hold = 5;
    set_client(3, 1'b1, 6'h15, 8'hC3);
    expect_issue(1'b1, 6'h15, 8'hC3);
    expect_done(3, 1'b0, 1'b0, 8'h00);
    c_req[3] = 1'b1;
    ack_cyc = 0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (reg_write_ack) begin
        ack_cyc++;
        if (reg_write_req || reg_read_req || c_ack != '0) viol++;
      end
      if (!busy) break;
    end
    check("sticky_ack_cycles", 32'(ack_cyc), 32'd5);
    check("sticky_no_activity", 32'(viol), 32'd0);
    phy_hold = 1;
    wait_done("sticky");

    // reset while a read is outstanding
    phy_noack = 1'b1;
    set_client(2, 1'b0, 6'h2C, 8'h00);
    expect_issue(1'b0, 6'h2C, 8'h00);
    c_req[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_read_req", 32'(reg_read_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    c_req = '0;
    @(posedge clk);
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    phy_noack = 1'b0;
    model_rdata = 8'h00;
    model_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);

    // clients 0 and 3 together: reset restored client 0 priority
    phy_rdata = 8'hA5;
    set_client(0, 1'b1, 6'h3F, 8'h99);
    set_client(3, 1'b0, 6'h01, 8'h00);
    expect_issue(1'b1, 6'h3F, 8'h99);
    expect_done(0, 1'b0, 1'b0, 8'h00);
    expect_issue(1'b0, 6'h01, 8'h00);
    expect_done(3, 1'b0, 1'b1, 8'hA5);
    c_req = 4'b1001;
    wait_done("post_reset_grant");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
